// File: rtl/dmem_responder.sv
// Data-side memory responder: posted-write FIFO that drains into a word array on bus-idle cycles,
// with youngest-entry read forwarding so reads always observe the latest write.
module dmem_responder #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned WBUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          MemRead,
  input  logic                          MemWrite,
  input  logic [ADDR_W-1:0]             dAddress,
  input  logic [31:0]                   dWriteData,
  output logic [31:0]                   dReadData,
  output logic                          rd_valid,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
  output logic                          wbuf_full,
  output logic                          err_misalign,
  output logic                          err_overflow,
  output logic                          err_conflict
);

  localparam int unsigned IdxW = ADDR_W - 2;
  localparam int unsigned PtrW = $clog2(WBUF_DEPTH);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StDrain = 1'b1;

  logic [IdxW-1:0] fifoIdx  [WBUF_DEPTH];
  logic [31:0]     fifoData [WBUF_DEPTH];
  logic [31:0]     mem      [DEPTH];

  logic [PtrW:0]   wrPtrQ, wrPtrD;
  logic [PtrW:0]   rdPtrQ, rdPtrD;
  logic [PtrW:0]   count;
  logic [0:0]      stateQ, stateD;

  logic [IdxW-1:0] wordIdx;
  logic            misalign, conflict, wrReq, rdReq, idleCyc;
  logic            full, push, drop, pop;
  logic [31:0]     rdVal;
  logic [PtrW:0]   offs;
  logic [PtrW-1:0] slot;
  logic [PtrW-1:0] headSlot;
  logic [PtrW-1:0] tailSlot;

  assign wordIdx  = dAddress[ADDR_W-1:2];
  assign headSlot = rdPtrQ[PtrW-1:0];
  assign tailSlot = wrPtrQ[PtrW-1:0];

  // Extra pointer bit makes the plain difference distinguish full from empty.
  assign count = wrPtrQ - rdPtrQ;
  assign full  = (count == (PtrW+1)'(WBUF_DEPTH));

  // Request classification, first match wins: misaligned, write (incl. conflict), read, idle.
  always_comb begin
    misalign = (MemRead || MemWrite) && (dAddress[1:0] != 2'b00);
    conflict = !misalign && MemRead && MemWrite;
    wrReq    = !misalign && MemWrite;
    rdReq    = !misalign && MemRead && !MemWrite;
    idleCyc  = !MemRead && !MemWrite;
    push     = wrReq && !full;
    drop     = wrReq && full;
    pop      = idleCyc && (stateQ == StDrain);
  end

  // Forwarding: scan oldest to youngest so the youngest matching entry overrides.
  always_comb begin
    rdVal = mem[wordIdx];
    offs  = '0;
    slot  = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      offs = i[PtrW:0];
      slot = headSlot + offs[PtrW-1:0];
      if ((offs < count) && (fifoIdx[slot] == wordIdx)) begin
        rdVal = fifoData[slot];
      end
    end
  end

  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    stateD = stateQ;
    if (push) begin
      wrPtrD = wrPtrQ + 1'b1;
    end
    if (pop) begin
      rdPtrD = rdPtrQ + 1'b1;
    end
    case (stateQ)
      StIdle: begin
        if (push) begin
          stateD = StDrain;
        end
      end
      StDrain: begin
        if (pop && (count == (PtrW+1)'(1))) begin
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtrQ       <= '0;
      rdPtrQ       <= '0;
      stateQ       <= StIdle;
      dReadData    <= '0;
      rd_valid     <= 1'b0;
      err_misalign <= 1'b0;
      err_overflow <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      wrPtrQ       <= wrPtrD;
      rdPtrQ       <= rdPtrD;
      stateQ       <= stateD;
      rd_valid     <= rdReq;
      err_misalign <= err_misalign | misalign;
      err_overflow <= err_overflow | drop;
      err_conflict <= err_conflict | conflict;
      if (rdReq) begin
        dReadData <= rdVal;
      end
    end
  end

  // Storage is never cleared; reset only blocks updates in its own cycle.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifoIdx[tailSlot]  <= wordIdx;
      fifoData[tailSlot] <= dWriteData;
    end
    if (!rst && pop) begin
      mem[fifoIdx[headSlot]] <= fifoData[headSlot];
    end
  end

  assign wbuf_count = count;
  assign wbuf_full  = full;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a queue-based model of the posted-write buffer.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst, MemRead, MemWrite;
  logic [8:0]  dAddress;
  logic [31:0] dWriteData;
  logic [31:0] dReadData;
  logic        rd_valid;
  logic [2:0]  wbuf_count;
  logic        wbuf_full, err_misalign, err_overflow, err_conflict;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(9), .DEPTH(128), .WBUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .dAddress(dAddress),
    .dWriteData(dWriteData), .dReadData(dReadData), .rd_valid(rd_valid),
    .wbuf_count(wbuf_count), .wbuf_full(wbuf_full), .err_misalign(err_misalign),
    .err_overflow(err_overflow), .err_conflict(err_conflict)
  );

  typedef struct {
    logic [6:0]  idx;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mdlMem [128];
  logic [31:0] expRd;
  logic        expValid, expMis, expOv, expCf;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] lookup(input logic [6:0] idx);
    logic [31:0] v;
    v = mdlMem[idx];
    foreach (q[i]) if (q[i].idx == idx) v = q[i].data;
    return v;
  endfunction

  // One bus cycle: drive, clock, advance the model, compare all outputs.
  task automatic cycle(input logic r, input logic rd, input logic wr,
                       input logic [8:0] a, input logic [31:0] d);
    logic mis;
    ent_t e;
    rst = r; MemRead = rd; MemWrite = wr; dAddress = a; dWriteData = d;
    @(posedge clk);
    mis = (rd || wr) && (a[1:0] != 2'b00);
    expValid = 1'b0;
    if (r) begin
      q.delete();
      expRd = '0; expMis = 1'b0; expOv = 1'b0; expCf = 1'b0;
    end else if (mis) begin
      expMis = 1'b1;
    end else if (wr) begin
      if (rd) expCf = 1'b1;
      if (q.size() < 4) q.push_back('{idx: a[8:2], data: d});
      else expOv = 1'b1;
    end else if (rd) begin
      expValid = 1'b1;
      expRd    = lookup(a[8:2]);
    end else if (q.size() > 0) begin
      e = q.pop_front();
      mdlMem[e.idx] = e.data;
    end
    #1;
    check("rd_valid", 32'(rd_valid), 32'(expValid));
    check("dReadData", dReadData, expRd);
    check("wbuf_count", 32'(wbuf_count), q.size());
    check("wbuf_full", 32'(wbuf_full), 32'(q.size() == 4));
    check("err_misalign", 32'(err_misalign), 32'(expMis));
    check("err_overflow", 32'(err_overflow), 32'(expOv));
    check("err_conflict", 32'(err_conflict), 32'(expCf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    cycle(1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [8:0] a);
    cycle(1'b0, 1'b1, 1'b0, a, 32'h0);
  endtask

  initial begin
    logic [31:0] oldVal;
    logic [8:0]  a;
    int          op;
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; dAddress = '0; dWriteData = '0;
    cycle(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
    check("reset dReadData", dReadData, 32'h0);
    check("reset count", 32'(wbuf_count), 32'h0);

    // Give every word a known value through the bus.
    for (int w = 0; w < 128; w++) begin
      a = 9'(w * 4);
      wr(a, $urandom);
      if (w % 4 == 3) idle(4);
    end

    // T1: reset discards a pending write
    oldVal = mdlMem[4];
    wr(9'h10, 32'h11);
    cycle(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
    check("T1 count", 32'(wbuf_count), 32'h0);
    check("T1 dReadData", dReadData, 32'h0);
    idle(3);
    rd(9'h10);
    check("T1 array", dReadData, oldVal);

    // T2: forward from FIFO
    wr(9'h20, 32'hDEADBEEF);
    rd(9'h20);
    check("T2 rd_valid", 32'(rd_valid), 32'h1);
    check("T2 data", dReadData, 32'hDEADBEEF);
    check("T2 count", 32'(wbuf_count), 32'h1);
    idle(4);

    // T3: youngest entry wins
    wr(9'h40, 32'h1);
    wr(9'h40, 32'h2);
    rd(9'h40);
    check("T3 fwd", dReadData, 32'h2);
    idle(2);
    check("T3 drained", 32'(wbuf_count), 32'h0);
    rd(9'h40);
    check("T3 array", dReadData, 32'h2);

    // T4: overflow drops the fifth write
    oldVal = mdlMem[4];
    for (int i = 0; i < 5; i++) wr(9'(i * 4), 32'(i + 1));
    check("T4 count", 32'(wbuf_count), 32'h4);
    check("T4 overflow", 32'(err_overflow), 32'h1);
    idle(4);
    for (int i = 0; i < 4; i++) begin
      rd(9'(i * 4));
      check("T4 data", dReadData, 32'(i + 1));
    end
    rd(9'h10);
    check("T4 dropped", dReadData, oldVal);

    // T5: misaligned and conflict
    rd(9'h22);
    check("T5 no rd_valid", 32'(rd_valid), 32'h0);
    check("T5 misalign", 32'(err_misalign), 32'h1);
    cycle(1'b0, 1'b1, 1'b1, 9'h24, 32'h55);
    check("T5 conflict", 32'(err_conflict), 32'h1);
    idle(4);
    rd(9'h24);
    check("T5 data", dReadData, 32'h55);

    // Random traffic, biased toward a few words to exercise forwarding hits.
    for (int n = 0; n < 3000; n++) begin
      op = $urandom_range(0, 99);
      if ($urandom_range(0, 1) == 1) a = {2'b00, 5'($urandom_range(0, 7)), 2'b00};
      else a = {7'($urandom_range(0, 127)), 2'b00};
      if (op < 40)      idle(1);
      else if (op < 65) rd(a);
      else if (op < 92) wr(a, $urandom);
      else if (op < 95) cycle(1'b0, 1'b1, 1'b1, a, $urandom);
      else if (op < 98) cycle(1'b0, op[0], ~op[0], a | 9'($urandom_range(1, 3)), $urandom);
      else              cycle(1'b1, op[0], 1'b1, a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
